// File: rtl/btle_pkg.sv
// ---------------------------------------------------------------------------
// btle_pkg
// Shared definitions for the BTLE PDU streaming block:
//   - default parameter widths for btle_pdu_stream_out
//   - PDU_HEADER_OCTETS: number of header octets preceding the payload
//   - pdu_state_e: state encoding of the PDU streaming FSM
// ---------------------------------------------------------------------------
package btle_pkg;

  localparam int DEF_PAYLOAD_LENGTH_BIT_WIDTH = 7;
  localparam int DEF_OCTET_ADDR_BIT_WIDTH     = 6;
  localparam int DEF_DROP_COUNT_BIT_WIDTH     = 16;

  localparam int PDU_HEADER_OCTETS = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } pdu_state_e;

endpackage

// File: rtl/btle_pdu_stream_out_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments by one on inc_i and sticks at all-ones.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   inc_i    in   increment enable
//   count_o  out  WIDTH-bit count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/btle_pdu_stream_out.sv
// ---------------------------------------------------------------------------
// btle_pdu_stream_out
// After each decode_end from btle_rx, reads the PDU (2 header octets plus
// payload_length payload octets, clamped to the RAM size) out of the PDU
// octet RAM in address order and presents it as a valid/ready byte stream.
//
// Optional feature, macro BTLE_PDU_DROP_BAD_CRC_EN:
//   defined   - packets with crc_ok = 0 are not streamed; drop_count counts them
//   undefined - every packet is streamed; drop_count stays 0
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   decode_end            one-cycle pulse: PDU RAM complete
//   crc_ok                CRC status, valid with decode_end
//   payload_length        payload octet count, valid with decode_end
//   pdu_octet_mem_addr    registered RAM read address
//   pdu_octet_mem_data    RAM read data, valid the cycle after the address
//   m_data/m_valid/m_last stream octet, valid flag, final-octet flag
//   m_crc_ok              crc_ok latched for the packet in flight
//   m_ready               sink accepts the octet
//   busy                  FSM not idle
//   overrun               one-cycle pulse: decode_end arrived while busy
//   drop_count            saturating count of dropped packets
//   dbg_state             current FSM state (pdu_state_e encoding)
//
// Handshake: an octet is transferred on a rising edge where m_valid and
// m_ready are both high. Once m_valid rises, m_data/m_last hold and m_valid
// stays high until that transfer; m_ready may be high before m_valid.
// ---------------------------------------------------------------------------
module btle_pdu_stream_out
  import btle_pkg::*;
#(
  parameter int PAYLOAD_LENGTH_BIT_WIDTH = DEF_PAYLOAD_LENGTH_BIT_WIDTH,
  parameter int OCTET_ADDR_BIT_WIDTH     = DEF_OCTET_ADDR_BIT_WIDTH,
  parameter int DROP_COUNT_BIT_WIDTH     = DEF_DROP_COUNT_BIT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                decode_end,
  input  logic                                crc_ok,
  input  logic [PAYLOAD_LENGTH_BIT_WIDTH-1:0] payload_length,
  output logic [OCTET_ADDR_BIT_WIDTH-1:0]     pdu_octet_mem_addr,
  input  logic [7:0]                          pdu_octet_mem_data,
  output logic [7:0]                          m_data,
  output logic                                m_valid,
  output logic                                m_last,
  output logic                                m_crc_ok,
  input  logic                                m_ready,
  output logic                                busy,
  output logic                                overrun,
  output logic [DROP_COUNT_BIT_WIDTH-1:0]     drop_count,
  output logic [1:0]                          dbg_state
);

  // Octet count needs one bit more than the address to represent the full RAM.
  localparam int          NW         = OCTET_ADDR_BIT_WIDTH + 1;
  localparam int          LW         = PAYLOAD_LENGTH_BIT_WIDTH + 1;
  localparam int unsigned MAX_OCTETS = 2 ** OCTET_ADDR_BIT_WIDTH;

  pdu_state_e                      state_q, state_d;
  logic [OCTET_ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [NW-1:0]                   n_q, n_d;
  logic [7:0]                      data_q, data_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic                            crc_q, crc_d;
  logic                            overrun_q, overrun_d;

  logic [LW-1:0]                   n_raw;
  logic [NW-1:0]                   n_clamped;
  logic                            drop_pkt;
  logic                            drop_event;

  assign n_raw = LW'(payload_length) + LW'(PDU_HEADER_OCTETS);

  always_comb begin
    n_clamped = '0;
    if (32'(n_raw) > MAX_OCTETS) begin
      n_clamped = NW'(MAX_OCTETS);
    end else begin
      n_clamped = NW'(n_raw);
    end
  end

`ifdef BTLE_PDU_DROP_BAD_CRC_EN
  assign drop_pkt = !crc_ok;
`else
  assign drop_pkt = 1'b0;
`endif

  // A bad-CRC packet is only dropped (and counted) when it would have started.
  assign drop_event = decode_end && (state_q == ST_IDLE) && drop_pkt;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    n_d       = n_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    crc_d     = crc_q;
    overrun_d = decode_end && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (decode_end && !drop_pkt) begin
          n_d     = n_clamped;
          crc_d   = crc_ok;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d  = pdu_octet_mem_data;
        valid_d = 1'b1;
        last_d  = ({1'b0, addr_q} == (n_q - NW'(1)));
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            addr_d  = '0;
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + OCTET_ADDR_BIT_WIDTH'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      n_q       <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      crc_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      n_q       <= n_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      crc_q     <= crc_d;
      overrun_q <= overrun_d;
    end
  end

  sat_counter #(
    .WIDTH (DROP_COUNT_BIT_WIDTH)
  ) u_drop_counter (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_event),
    .count_o (drop_count)
  );

  assign pdu_octet_mem_addr = addr_q;
  assign m_data             = data_q;
  assign m_valid            = valid_q;
  assign m_last             = last_q;
  assign m_crc_ok           = crc_q;
  assign busy               = (state_q != ST_IDLE);
  assign overrun            = overrun_q;
  assign dbg_state          = state_q;

endmodule
